// File: rtl/uart_rx_bit_sampler.sv
// UART receive bit sampler: times each bit from the start-detector pulse, takes a
// three-point majority vote near mid-bit and assembles the data word plus frame status.
module uart_rx_bit_sampler #(
  parameter int unsigned CLOCKS_PER_BIT = 5000,
  parameter int unsigned SAMPLE_GAP     = 1,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_detected,
  input  logic                 serial_in,
  output logic                 busy,
  output logic                 sampling_strobe,
  output logic                 sampled_bit,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_done,
  output logic                 framing_error,
  output logic                 noise_detected,
  output logic                 false_start
);

  localparam int unsigned CNT_W   = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS + STOP_BITS) + 1;
  localparam int unsigned MID     = CLOCKS_PER_BIT / 2;
  localparam int unsigned VOTE0   = MID - SAMPLE_GAP;
  localparam int unsigned VOTE2   = MID + SAMPLE_GAP;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 v0_q, v1_q;
  logic                 noise_q, ferr_q;
  logic                 busy_q, strobe_q, bit_q;
  logic                 done_q, ferr_out_q, noise_out_q, fstart_q;
  logic [DATA_BITS-1:0] data_q;

  logic at_wrap, at_vote0, at_vote1, at_vote2;
  logic vote_maj, votes_differ;

  // Third vote is taken straight from the line on the capturing edge.
  assign at_wrap      = (cnt_q == CNT_W'(CLOCKS_PER_BIT - 1));
  assign at_vote0     = (cnt_q == CNT_W'(VOTE0));
  assign at_vote1     = (cnt_q == CNT_W'(MID));
  assign at_vote2     = (cnt_q == CNT_W'(VOTE2));
  assign vote_maj     = (v0_q & v1_q) | (v0_q & serial_in) | (v1_q & serial_in);
  assign votes_differ = !((v0_q == v1_q) && (v1_q == serial_in));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      noise_q     <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
      strobe_q    <= 1'b0;
      bit_q       <= 1'b0;
      done_q      <= 1'b0;
      ferr_out_q  <= 1'b0;
      noise_out_q <= 1'b0;
      fstart_q    <= 1'b0;
      data_q      <= '0;
    end else begin
      strobe_q    <= 1'b0;
      bit_q       <= 1'b0;
      done_q      <= 1'b0;
      ferr_out_q  <= 1'b0;
      noise_out_q <= 1'b0;
      fstart_q    <= 1'b0;
      if (state_q == IDLE) begin
        if (start_detected) begin
          state_q <= START;
          cnt_q   <= '0;
          idx_q   <= '0;
          noise_q <= 1'b0;
          ferr_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
      end else begin
        cnt_q <= at_wrap ? '0 : cnt_q + CNT_W'(1);
        if (at_vote0) v0_q <= serial_in;
        if (at_vote1) v1_q <= serial_in;
        if (at_vote2) begin
          strobe_q <= 1'b1;
          bit_q    <= vote_maj;
          if (votes_differ) noise_q <= 1'b1;
        end
        case (state_q)
          START: begin
            if (at_vote2 && vote_maj) begin
              fstart_q <= 1'b1;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              cnt_q    <= '0;
            end else if (at_wrap) begin
              state_q <= DATA;
              idx_q   <= '0;
            end
          end
          DATA: begin
            if (at_vote2) begin
              for (int unsigned i = 0; i < DATA_BITS; i++) begin
                if (idx_q == IDX_W'(i)) data_q[i] <= vote_maj;
              end
            end
            if (at_wrap) begin
              if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                state_q <= STOP;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end
          STOP: begin
            // Finish on the last stop vote; the rest of the stop bit is not waited out.
            if (at_vote2 && (idx_q == IDX_W'(STOP_BITS - 1))) begin
              done_q      <= 1'b1;
              ferr_out_q  <= ferr_q | !vote_maj;
              noise_out_q <= noise_q | votes_differ;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              cnt_q       <= '0;
              idx_q       <= '0;
            end else begin
              if (at_vote2 && !vote_maj) ferr_q <= 1'b1;
              if (at_wrap) idx_q <= idx_q + IDX_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy            = busy_q;
  assign sampling_strobe = strobe_q;
  assign sampled_bit     = bit_q;
  assign data_out        = data_q;
  assign frame_done      = done_q;
  assign framing_error   = ferr_out_q;
  assign noise_detected  = noise_out_q;
  assign false_start     = fstart_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Bench for uart_rx_bit_sampler: per-edge stimulus tables replayed into a 1-stop and a
// 2-stop instance, checked every cycle against a frame-level event model.
module tb_uart_rx_bit_sampler;

  localparam int NMAX = 400;

  logic clk = 1'b0;
  logic rst, start_det, rx;
  logic       busy1, stb1, bit1, fd1, fe1, nd1, fs1;
  logic       busy2, stb2, bit2, fd2, fe2, nd2, fs2;
  logic [7:0] data1, data2;

  always #5 clk = ~clk;

  uart_rx_bit_sampler #(.CLOCKS_PER_BIT(16), .SAMPLE_GAP(1), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset(rst), .start_detected(start_det), .serial_in(rx),
    .busy(busy1), .sampling_strobe(stb1), .sampled_bit(bit1), .data_out(data1),
    .frame_done(fd1), .framing_error(fe1), .noise_detected(nd1), .false_start(fs1));

  uart_rx_bit_sampler #(.CLOCKS_PER_BIT(16), .SAMPLE_GAP(1), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(rst), .start_detected(start_det), .serial_in(rx),
    .busy(busy2), .sampling_strobe(stb2), .sampled_bit(bit2), .data_out(data2),
    .frame_done(fd2), .framing_error(fe2), .noise_detected(nd2), .false_start(fs2));

  // Stimulus per edge index, and expected per-cycle outputs per instance.
  logic       line_a [NMAX];
  logic       sd_a   [NMAX];
  logic       rst_a  [NMAX];
  logic [6:0] exp_vec [2][NMAX];
  logic       chk_d   [2][NMAX];
  logic [7:0] exp_d   [2][NMAX];

  int n_cmp = 0;
  int n_bad = 0;
  int fd_first [2];
  int fd_last  [2];
  int fs_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      line_a[i] = 1'b1;
      sd_a[i]   = 1'b0;
      rst_a[i]  = 1'b0;
    end
    rst_a[0] = 1'b1;
  endtask

  // Wire image of a frame: start, 8 data LSB first, two stop levels; start pulse at e0.
  task automatic put_frame(input int e0, input logic [7:0] d, input logic stop0, input logic stop1);
    logic b;
    sd_a[e0] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 0)      b = 1'b0;
      else if (k <= 8) b = d[k-1];
      else if (k == 9) b = stop0;
      else             b = stop1;
      for (int j = 1; j <= 16; j++)
        if (e0 + 16*k + j < NMAX) line_a[e0 + 16*k + j] = b;
    end
  endtask

  // Frame-level model: bit k of a frame started at edge e0 is voted at edges
  // e0+16k+8..10 and reported in cycle e0+16k+10.
  task automatic model(input int inst, input int n);
    int e, e0, k, s, from, endc, abt, nb;
    logic a, b, d, maj, dis, noisy, ferr, done;
    logic [7:0] held, dd;
    nb = 1 + 8 + inst + 1;
    for (int c = 0; c < NMAX; c++) begin
      exp_vec[inst][c] = '0;
      chk_d[inst][c]   = 1'b0;
      exp_d[inst][c]   = '0;
    end
    held = '0;
    e = 0;
    while (e < n) begin
      if (rst_a[e]) begin
        held = '0;
        chk_d[inst][e] = 1'b1;
        exp_d[inst][e] = '0;
        e++;
      end else if (sd_a[e]) begin
        e0 = e; noisy = 1'b0; ferr = 1'b0; dd = held; done = 1'b0;
        k = 0; endc = -1; abt = -1; from = e0 + 1;
        while (!done && abt < 0) begin
          s = e0 + 16*k + 10;
          for (int c = from; c <= s; c++)
            if (abt < 0 && (c >= n || rst_a[c])) abt = c;
          if (abt < 0) begin
            a = line_a[s-2]; b = line_a[s-1]; d = line_a[s];
            maj = (a & b) | (a & d) | (b & d);
            dis = !((a == b) && (b == d));
            exp_vec[inst][s][5] = 1'b1;
            exp_vec[inst][s][4] = maj;
            noisy = noisy | dis;
            if (k == 0 && maj) begin
              exp_vec[inst][s][0] = 1'b1;
              endc = s; done = 1'b1;
            end else if (k >= 1 && k <= 8) begin
              dd[k-1] = maj;
            end else if (k > 8) begin
              ferr = ferr | !maj;
              if (k == nb - 1) begin
                exp_vec[inst][s][3] = 1'b1;
                exp_vec[inst][s][2] = ferr;
                exp_vec[inst][s][1] = noisy;
                chk_d[inst][s] = 1'b1;
                exp_d[inst][s] = dd;
                held = dd;
                endc = s; done = 1'b1;
              end
            end
            from = s + 1;
            k++;
          end
        end
        for (int c = e0; c < ((abt >= 0) ? abt : endc); c++) exp_vec[inst][c][6] = 1'b1;
        e = (abt >= 0) ? abt : endc + 1;
      end else begin
        chk_d[inst][e] = 1'b1;
        exp_d[inst][e] = held;
        e++;
      end
    end
  endtask

  task automatic run(input int n);
    logic [6:0] o1, o2;
    model(0, n);
    model(1, n);
    fd_first = '{-1, -1};
    fd_last  = '{-1, -1};
    fs_first = -1;
    for (int e = 0; e < n; e++) begin
      rst = rst_a[e]; start_det = sd_a[e]; rx = line_a[e];
      @(posedge clk);
      #1;
      o1 = {busy1, stb1, stb1 & bit1, fd1, fe1, nd1, fs1};
      o2 = {busy2, stb2, stb2 & bit2, fd2, fe2, nd2, fs2};
      check($sformatf("out1@%0d", e), 32'(o1), 32'(exp_vec[0][e]));
      check($sformatf("out2@%0d", e), 32'(o2), 32'(exp_vec[1][e]));
      if (chk_d[0][e]) check($sformatf("data1@%0d", e), 32'(data1), 32'(exp_d[0][e]));
      if (chk_d[1][e]) check($sformatf("data2@%0d", e), 32'(data2), 32'(exp_d[1][e]));
      if (fd1) begin if (fd_first[0] < 0) fd_first[0] = e; fd_last[0] = e; end
      if (fd2) begin if (fd_first[1] < 0) fd_first[1] = e; fd_last[1] = e; end
      if (fs1 && fs_first < 0) fs_first = e;
    end
  endtask

  initial begin
    int e0, e1;
    rst = 1'b1; start_det = 1'b0; rx = 1'b1;

    // Clean 0xA5 frame.
    clear_stim();
    put_frame(5, 8'hA5, 1'b1, 1'b1);
    run(200);
    check("a5_done_cycle", 32'(fd_first[0]), 32'(5 + 154));
    check("a5_done_cycle_2stop", 32'(fd_first[1]), 32'(5 + 170));

    // Line back high at the start-bit midpoint.
    clear_stim();
    put_frame(5, 8'hA5, 1'b1, 1'b1);
    line_a[13] = 1'b1; line_a[14] = 1'b1; line_a[15] = 1'b1;
    run(60);
    check("false_start_cycle", 32'(fs_first), 32'(5 + 10));
    check("false_start_no_done", 32'(fd_first[0]), 32'hFFFF_FFFF);

    // Stop bit low.
    clear_stim();
    put_frame(5, 8'h5A, 1'b0, 1'b1);
    run(200);

    // Middle vote of data bit 3 glitched.
    clear_stim();
    put_frame(5, 8'h96, 1'b1, 1'b1);
    line_a[5 + 64 + 9] = ~line_a[5 + 64 + 9];
    run(200);

    // Back-to-back frames with stray start pulses while busy.
    clear_stim();
    put_frame(5, 8'h3C, 1'b1, 1'b1);
    put_frame(160, 8'hC3, 1'b1, 1'b1);
    sd_a[40] = 1'b1; sd_a[100] = 1'b1;
    run(360);
    check("b2b_second_done", 32'(fd_last[0]), 32'(160 + 154));

    // Reset mid-DATA (together with a start pulse), then a fresh frame.
    clear_stim();
    put_frame(5, 8'hE7, 1'b1, 1'b1);
    rst_a[65] = 1'b1; sd_a[65] = 1'b1;
    put_frame(80, 8'h81, 1'b1, 1'b1);
    run(280);
    check("after_reset_done", 32'(fd_first[0]), 32'(80 + 154));

    // Randomized frames, glitches, stop levels and follow-on frames.
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      e0 = int'($urandom_range(1, 10));
      put_frame(e0, 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        e1 = int'($urandom_range(e0, e0 + 180));
        line_a[e1] = ~line_a[e1];
      end
      if ($urandom_range(0, 1) == 1) sd_a[int'($urandom_range(e0 + 1, e0 + 150))] = 1'b1;
      if ($urandom_range(0, 1) == 1)
        put_frame(e0 + 155 + int'($urandom_range(0, 20)), 8'($urandom), 1'b1, 1'b1);
      run(399);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
